// File: rtl/serial_adder_if.sv
// Request/result bundle between the requesting logic and the bit-serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell plus a carry flop, LSB first,
// one bit per clock, start/busy/done handshake.

// Single-bit full adder cell.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c_in,
  output logic o_s,
  output logic o_c_out
);
  assign o_s     = i_a ^ i_b ^ i_c_in;
  assign o_c_out = (i_a & i_b) | (i_a & i_c_in) | (i_b & i_c_in);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             w_fa_s;
  logic             w_fa_c;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_nx;
  logic             w_busy;
  logic             w_done;

  // A request is taken whenever no addition is in flight (IDLE or DONE).
  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_last   = (r_cnt == LAST);

  full_adder u_fa (
    .i_a     (r_a[0]),
    .i_b     (r_b[0]),
    .i_c_in  (r_carry),
    .o_s     (w_fa_s),
    .o_c_out (w_fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
  assign w_sum_nx = WIDTH'({w_fa_s, r_sum} >> 1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nx = S_RUN;
      S_RUN:   if (w_last)    w_state_nx = S_DONE;
      S_DONE:  w_state_nx = bus.start ? S_RUN : S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Operand load on accept, one bit step per cycle in RUN; results held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_sum   <= w_sum_nx;
      r_carry <= w_fa_c;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) r_cout <= w_fa_c;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.c_in;
      r_cnt   <= '0;
    end
  end

  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.sum   = r_sum;
  assign bus.c_out = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances, scoreboard of {c_out,sum}.
module tb_serial_adder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
  serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int total = 0;
  int bad   = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until done is seen (bounded). Optionally hold start, or re-pulse
  // start with different operands at cycle rp of RUN.
  task automatic wait8(input bit hold, input int rp, output int cyc, output int nb);
    cyc = 0;
    nb  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!hold) bus8.start = 1'b0;
      if (!hold && cyc == 1) begin
        bus8.a    = ~bus8.a;
        bus8.b    = ~bus8.b;
        bus8.c_in = ~bus8.c_in;
      end
      if (cyc == rp) begin
        bus8.start = 1'b1;
        bus8.a     = 8'hAA;
        bus8.b     = 8'h55;
        bus8.c_in  = 1'b0;
      end
      if (bus8.busy) nb++;
    end while (!bus8.done && cyc < 40);
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input bit hold, input int rp, input string tag);
    int cyc, nb;
    logic [8:0] exp;
    bus8.a     = a;
    bus8.b     = b;
    bus8.c_in  = c;
    bus8.start = 1'b1;
    q8.push_back(9'(a) + 9'(b) + 9'(c));
    wait8(hold, rp, cyc, nb);
    chk({tag, "_latency"}, cyc, 9);
    chk({tag, "_busycycles"}, nb, 8);
    chk({tag, "_done"}, bus8.done, 1);
    exp = q8.pop_front();
    chk({tag, "_result"}, {bus8.c_out, bus8.sum}, exp);
  endtask

  task automatic go1(input logic a, input logic b, input logic c);
    int cyc, nb;
    logic [1:0] exp;
    bus1.a     = a;
    bus1.b     = b;
    bus1.c_in  = c;
    bus1.start = 1'b1;
    q1.push_back(2'(a) + 2'(b) + 2'(c));
    cyc = 0;
    nb  = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus1.start = 1'b0;
      if (bus1.busy) nb++;
    end while (!bus1.done && cyc < 20);
    chk($sformatf("w1_latency_%0d%0d%0d", a, b, c), cyc, 2);
    chk($sformatf("w1_busy_%0d%0d%0d", a, b, c), nb, 1);
    exp = q1.pop_front();
    chk($sformatf("w1_result_%0d%0d%0d", a, b, c), {bus1.c_out, bus1.sum}, exp);
  endtask

  initial begin
    int nd, nbz;
    reset      = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus8.busy, 0);
    chk("rst_done", bus8.done, 0);
    chk("rst_sum", bus8.sum, 0);
    chk("rst_cout", bus8.c_out, 0);
    chk("rst_w1", {bus1.busy, bus1.done, bus1.c_out, bus1.sum}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus8.busy, 0);

    // Basic additions
    go8(8'h5A, 8'h3C, 1'b0, 1'b0, 0, "basic");
    @(negedge clk);
    chk("basic_done_once", bus8.done, 0);
    chk("basic_hold", {bus8.c_out, bus8.sum}, 9'h096);
    go8(8'hFF, 8'h01, 1'b0, 1'b0, 0, "ovf");
    go8(8'hFF, 8'hFF, 1'b1, 1'b0, 0, "max");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_%0d", i), {bus8.done, bus8.c_out, bus8.sum}, 10'h1FF);
    end

    // start during RUN must be ignored
    go8(8'h10, 8'h20, 1'b0, 1'b0, 3, "prot");
    nd = 0; nbz = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus8.done) nd++;
      if (bus8.busy) nbz++;
    end
    chk("prot_no_second_done", nd, 0);
    chk("prot_no_second_busy", nbz, 0);
    chk("prot_result_held", {bus8.c_out, bus8.sum}, 9'h030);

    // Back-to-back with start held, operands switched on the done cycle
    go8(8'h01, 8'h02, 1'b0, 1'b1, 0, "b2b_first");
    go8(8'h80, 8'h80, 1'b0, 1'b0, 0, "b2b_second");
    @(negedge clk);
    chk("b2b_idle", {bus8.busy, bus8.done}, 0);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) go1(i[2], i[1], i[0]);

    // Asynchronous reset mid-operation
    bus8.a = 8'h11; bus8.b = 8'h22; bus8.c_in = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", bus8.busy, 1);
    chk("pre_rst_partial", {bus8.c_out, bus8.sum}, 9'h160);
    chk("pre_rst_w1", {bus1.c_out, bus1.sum}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", bus8.busy, 0);
    chk("arst_done", bus8.done, 0);
    chk("arst_sum", bus8.sum, 0);
    chk("arst_cout", bus8.c_out, 0);
    chk("arst_w1", {bus1.c_out, bus1.sum}, 0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) nd++;
    end
    chk("arst_no_done", nd, 0);
    go8(8'h7F, 8'h01, 1'b1, 1'b0, 0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
